// File: rtl/log_record_serializer.sv
// Log record serializer: filters incoming log records against a runtime minimum
// level, queues them in a record FIFO and emits each one as a framed byte stream
// (A5, level, tag, payload MSB first, XOR checksum). The producer is never stalled;
// overflow and filtered records are counted with saturating counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   min_level                filter threshold (records below it are discarded)
//   rec_valid/level/tag/payload  record input, consumed every valid cycle
//   byte_valid/ready/data    output byte stream with valid/ready handshake
//   filt_count, drop_count   saturating discard counters
//   busy                     FIFO non-empty or frame in progress
module log_record_serializer #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned PAYLOAD_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   min_level,
  input  logic                         rec_valid,
  input  logic [2:0]                   rec_level,
  input  logic [7:0]                   rec_tag,
  input  logic [8*PAYLOAD_BYTES-1:0]   rec_payload,
  output logic                         byte_valid,
  input  logic                         byte_ready,
  output logic [7:0]                   byte_data,
  output logic [15:0]                  filt_count,
  output logic [15:0]                  drop_count,
  output logic                         busy
);

  localparam int unsigned PW    = 8 * PAYLOAD_BYTES;
  localparam int unsigned REC_W = 11 + PW;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEVEL, S_TAG, S_PAYLOAD, S_CSUM
  } state_t;

  state_t           state;
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic [2:0]       hold_level;
  logic [7:0]       hold_tag;
  logic [PW-1:0]    shreg;
  logic [7:0]       hold_csum;
  logic [IDX_W-1:0] idx;

  logic             filt_hit_c, full_c, push_c, pop_c, frame_active_nxt_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic [REC_W-1:0] head_c;
  logic [7:0]       head_csum_c;

  // Accept / push / pop decisions; full uses pre-pop occupancy
  always_comb begin
    filt_hit_c = rec_valid && (rec_level < min_level);
    full_c     = (count == CNT_W'(FIFO_DEPTH));
    push_c     = rec_valid && !filt_hit_c && !full_c;
    pop_c      = (state == S_IDLE) && (count != '0);
    head_c     = mem[rd_ptr];
  end

  // Occupancy and frame activity after this edge, used for registered busy
  always_comb begin
    count_nxt_c = count;
    if (push_c && !pop_c)      count_nxt_c = count + CNT_W'(1);
    else if (!push_c && pop_c) count_nxt_c = count - CNT_W'(1);
    case (state)
      S_IDLE:  frame_active_nxt_c = pop_c;
      S_CSUM:  frame_active_nxt_c = !byte_ready;
      default: frame_active_nxt_c = 1'b1;
    endcase
  end

  // Checksum of the head record: level byte, tag and all payload bytes
  always_comb begin
    head_csum_c = {5'b0, head_c[REC_W-1 -: 3]} ^ head_c[PW +: 8];
    for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
      head_csum_c = head_csum_c ^ head_c[i*8 +: 8];
    end
  end

  // Record storage (no reset needed; validity tracked by count)
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= {rec_level, rec_tag, rec_payload};
  end

  // FIFO pointers, counters, busy and the framing FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      filt_count <= 16'h0000;
      drop_count <= 16'h0000;
      busy       <= 1'b0;
      hold_level <= 3'd0;
      hold_tag   <= 8'h00;
      shreg      <= '0;
      hold_csum  <= 8'h00;
      idx        <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt_c;
      busy  <= (count_nxt_c != '0) || frame_active_nxt_c;

      if (filt_hit_c && filt_count != 16'hFFFF) filt_count <= filt_count + 16'd1;
      if (rec_valid && !filt_hit_c && full_c && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;

      case (state)
        S_IDLE: begin
          byte_valid <= 1'b0;
          if (pop_c) begin
            hold_level <= head_c[REC_W-1 -: 3];
            hold_tag   <= head_c[PW +: 8];
            shreg      <= head_c[PW-1:0];
            hold_csum  <= head_csum_c;
            byte_valid <= 1'b1;
            byte_data  <= 8'hA5;
            state      <= S_SYNC;
          end
        end
        S_SYNC: if (byte_ready) begin
          byte_data <= {5'b0, hold_level};
          state     <= S_LEVEL;
        end
        S_LEVEL: if (byte_ready) begin
          byte_data <= hold_tag;
          state     <= S_TAG;
        end
        S_TAG: if (byte_ready) begin
          byte_data <= shreg[PW-1 -: 8];
          shreg     <= shreg << 8;
          idx       <= '0;
          state     <= S_PAYLOAD;
        end
        S_PAYLOAD: if (byte_ready) begin
          if (idx == IDX_W'(PAYLOAD_BYTES - 1)) begin
            byte_data <= hold_csum;
            state     <= S_CSUM;
          end else begin
            byte_data <= shreg[PW-1 -: 8];
            shreg     <= shreg << 8;
            idx       <= idx + IDX_W'(1);
          end
        end
        S_CSUM: if (byte_ready) begin
          byte_valid <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log_record_serializer.sv
// Testbench for log_record_serializer: queue-level reference model checked on
// every cycle, directed scenarios with literal expectations, and a random phase.
module tb_log_record_serializer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PB    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    min_level;
  logic          rec_valid;
  logic [2:0]    rec_level;
  logic [7:0]    rec_tag;
  logic [31:0]   rec_payload;
  logic          byte_valid;
  logic          byte_ready;
  logic [7:0]    byte_data;
  logic [15:0]   filt_count;
  logic [15:0]   drop_count;
  logic          busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  log_record_serializer #(.FIFO_DEPTH(DEPTH), .PAYLOAD_BYTES(PB)) dut (
    .clk(clk), .rst(rst), .min_level(min_level), .rec_valid(rec_valid),
    .rec_level(rec_level), .rec_tag(rec_tag), .rec_payload(rec_payload),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .filt_count(filt_count), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [2:0] lvl; logic [7:0] tag; logic [31:0] pl; } rec_t;
  rec_t        fq[$];        // queued records
  logic [7:0]  bq[$];        // remaining bytes of frame on the wire
  int          m_filt = 0;
  int          m_drop = 0;

  always @(posedge clk) begin
    if (rst) begin
      fq.delete(); bq.delete(); m_filt = 0; m_drop = 0;
    end else begin
      int   pre;
      rec_t r;
      logic [7:0] cs;
      pre = fq.size();
      if (bq.size() > 0) begin
        if (byte_ready) void'(bq.pop_front());
      end else if (pre > 0) begin
        r = fq.pop_front();
        cs = {5'b0, r.lvl} ^ r.tag;
        bq.push_back(8'hA5);
        bq.push_back({5'b0, r.lvl});
        bq.push_back(r.tag);
        for (int i = PB - 1; i >= 0; i--) begin
          bq.push_back(r.pl[i*8 +: 8]);
          cs = cs ^ r.pl[i*8 +: 8];
        end
        bq.push_back(cs);
      end
      if (rec_valid) begin
        if (rec_level < min_level) begin
          if (m_filt < 65535) m_filt++;
        end else if (pre == DEPTH) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          r.lvl = rec_level; r.tag = rec_tag; r.pl = rec_payload;
          fq.push_back(r);
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus capture of accepted bytes
  logic [7:0] cap[$];
  always @(negedge clk) begin
    if (chk_en) begin
      chk("byte_valid", 32'(byte_valid), 32'(bq.size() > 0));
      if (bq.size() > 0) chk("byte_data", 32'(byte_data), 32'(bq[0]));
      chk("busy", 32'(busy), 32'((fq.size() > 0) || (bq.size() > 0)));
      chk("filt_count", 32'(filt_count), 32'(m_filt));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
    end
    if (byte_valid === 1'b1 && byte_ready === 1'b1) cap.push_back(byte_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rec_valid = 1'b0;
    tick();
    rst = 1'b0;
    cap.delete();
  endtask

  task automatic send(input logic [2:0] l, input logic [7:0] t, input logic [31:0] p);
    rec_valid = 1'b1; rec_level = l; rec_tag = t; rec_payload = p;
    tick();
    rec_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick(); n++;
    end
    if (busy !== 1'b0) chk({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  logic [7:0] exp2 [8];
  int nv;

  initial begin
    exp2[0] = 8'hA5; exp2[1] = 8'h04; exp2[2] = 8'h3C; exp2[3] = 8'h11;
    exp2[4] = 8'h22; exp2[5] = 8'h33; exp2[6] = 8'h44; exp2[7] = 8'h7C;
    rst = 1'b1; min_level = 3'd0; rec_valid = 1'b0; rec_level = 3'd0;
    rec_tag = 8'h00; rec_payload = 32'h0; byte_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_valid", 32'(byte_valid), 32'd0);
    chk("reset_data", 32'(byte_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cnts", {filt_count, drop_count}, 32'd0);
    chk_en = 1'b1;

    // 1: filtered record produces nothing
    min_level = 3'd2; byte_ready = 1'b1;
    send(3'd1, 8'h55, 32'hCAFEF00D);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      if (byte_valid) nv++;
      tick();
    end
    chk("t1_no_bytes", 32'(nv), 32'd0);
    chk("t1_filt", 32'(filt_count), 32'd1);
    chk("t1_drop", 32'(drop_count), 32'd0);

    // 2: single frame, latency N+2, literal bytes
    do_reset();
    min_level = 3'd0; byte_ready = 1'b1;
    send(3'd4, 8'h3C, 32'h11223344);
    chk("t2_lat_n1", 32'(byte_valid), 32'd0);
    tick();
    chk("t2_lat_n2_valid", 32'(byte_valid), 32'd1);
    chk("t2_lat_n2_data", 32'(byte_data), 32'hA5);
    wait_idle("t2", 40);
    chk("t2_len", 32'(cap.size()), 32'd8);
    for (int i = 0; i < 8 && i < cap.size(); i++) chk($sformatf("t2_byte%0d", i), 32'(cap[i]), 32'(exp2[i]));
    chk("t2_busy_after", 32'(busy), 32'd0);

    // 3: stalled sink, same byte sequence
    do_reset();
    byte_ready = 1'b1;
    send(3'd4, 8'h3C, 32'h11223344);
    for (int k = 0; k < 60 && busy; k++) begin
      byte_ready = ((k % 3) == 0);
      tick();
    end
    byte_ready = 1'b1;
    wait_idle("t3", 40);
    chk("t3_len", 32'(cap.size()), 32'd8);
    for (int i = 0; i < 8 && i < cap.size(); i++) chk($sformatf("t3_byte%0d", i), 32'(cap[i]), 32'(exp2[i]));

    // 4: overflow with blocked sink
    do_reset();
    byte_ready = 1'b0;
    for (int i = 0; i < 12; i++) send(3'd4, 8'(i), $urandom);
    tick(); tick();
    chk("t4_drop", 32'(drop_count), 32'd3);
    byte_ready = 1'b1;
    wait_idle("t4", 300);
    chk("t4_len", 32'(cap.size()), 32'd72);
    for (int f = 0; f < 9 && (f*8+2) < cap.size(); f++) begin
      chk($sformatf("t4_sync%0d", f), 32'(cap[f*8]), 32'hA5);
      chk($sformatf("t4_tag%0d", f), 32'(cap[f*8+2]), 32'(f));
    end

    // 5: reset during payload byte 1 with records queued
    do_reset();
    byte_ready = 1'b0;
    send(3'd5, 8'h77, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) send(3'd3, 8'(8'h80 + i), $urandom);
    chk("t5_sync", 32'(byte_data), 32'hA5);
    byte_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_at_p1", 32'(byte_data), 32'hAD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", 32'(byte_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cnts", {filt_count, drop_count}, 32'd0);
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (byte_valid) nv++;
      tick();
    end
    chk("t5_quiet", 32'(nv), 32'd0);

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) rst = 1'b1; else rst = 1'b0;
      if ($urandom_range(0, 49) == 0) min_level = 3'($urandom_range(0, 7));
      rec_valid   = ($urandom_range(0, 2) == 0);
      rec_level   = 3'($urandom_range(0, 7));
      rec_tag     = 8'($urandom);
      rec_payload = $urandom;
      byte_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; rec_valid = 1'b0; byte_ready = 1'b1;
    wait_idle("rand_drain", 200);

    // 6: filter counter saturation
    do_reset();
    min_level = 3'd7;
    rec_valid = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      rec_level = 3'($urandom_range(0, 6));
      tick();
    end
    rec_valid = 1'b0;
    tick();
    chk("t6_filt_sat", 32'(filt_count), 32'h0000FFFF);
    chk("t6_drop", 32'(drop_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
